// File: rtl/mac_sequencer.sv
// MACH/MACL sequencer: turns decoded multiply/MAC/LDS/CLRMAC requests into datapath operand writes.
// Latency: ACK same cycle; 1-2 write phases then LAT_* EXEC cycles (all counted in CE_R cycles).
// Backpressure: STALL holds the pipeline on new requests or MAC reads while busy; nothing advances when CE_R=0.
// Opcode map: 0001 MUL.L, 0010 DMULU.L, 0011 DMULS.L, 1001 MAC.L, 1011 MAC.W,
// 0110 MULU.W, 0111 MULS.W, 0000/1000 LDS, 1111 CLRMAC; all other codes are NOPs.
// LAT_* must each be within 1..7 (3-bit countdown).
module mac_sequencer #(
  parameter int LAT_MULW = 1,
  parameter int LAT_MULL = 2,
  parameter int LAT_DMUL = 3,
  parameter int LAT_MACW = 2,
  parameter int LAT_MACL = 3
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CE_R,
  input  logic       REQ,
  input  logic [3:0] OP,
  input  logic       SAT,
  input  logic [1:0] TGT,
  input  logic       RD_MAC,
  output logic       ACK,
  output logic       STALL,
  output logic       BUSY,
  output logic       OPND_SEL,
  output logic [1:0] MAC_SEL,
  output logic [3:0] MAC_OP,
  output logic       MAC_S,
  output logic       MAC_WE
);

  typedef enum logic [1:0] {IDLE, OPA, OPB, EXEC} state_t;

  state_t     state;
  logic [2:0] cnt;
  logic [3:0] op_q;
  logic       sat_q;
  logic [1:0] tgt_q;

  function automatic logic is_two(input logic [3:0] op);
    return op inside {4'b0001, 4'b0010, 4'b0011, 4'b1001, 4'b1011};
  endfunction

  function automatic logic is_mulw(input logic [3:0] op);
    return op inside {4'b0110, 4'b0111};
  endfunction

  function automatic logic is_nox(input logic [3:0] op);
    return op inside {4'b0000, 4'b1000, 4'b1111};
  endfunction

  // Register select for the final write phase: LDS uses its target, CLRMAC hits both.
  function automatic logic [1:0] last_sel(input logic [3:0] op, input logic [1:0] tgt);
    if (op == 4'b0000 || op == 4'b1000) return tgt;
    else if (op == 4'b1111)             return 2'b11;
    else                                return 2'b10;
  endfunction

  function automatic logic [2:0] lat_of(input logic [3:0] op);
    case (op)
      4'b0110, 4'b0111: return 3'(LAT_MULW);
      4'b0001:          return 3'(LAT_MULL);
      4'b0010, 4'b0011: return 3'(LAT_DMUL);
      4'b1011:          return 3'(LAT_MACW);
      4'b1001:          return 3'(LAT_MACL);
      default:          return 3'd1;
    endcase
  endfunction

  // Handshake outputs depend on the live request, so they are combinational off registered BUSY.
  always_comb begin
    ACK   = REQ & CE_R & ~BUSY;
    STALL = BUSY & (REQ | RD_MAC);
  end

  assign MAC_OP = op_q;
  assign MAC_S  = sat_q;

  // Sequencer FSM; datapath strobes are registered alongside the state they belong to.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      cnt      <= '0;
      op_q     <= '0;
      sat_q    <= 1'b0;
      tgt_q    <= '0;
      BUSY     <= 1'b0;
      MAC_WE   <= 1'b0;
      MAC_SEL  <= '0;
      OPND_SEL <= 1'b0;
    end else if (CE_R) begin
      case (state)
        IDLE: begin
          if (REQ) begin
            op_q  <= OP;
            sat_q <= SAT;
            tgt_q <= TGT;
            if (is_two(OP)) begin
              state    <= OPA;
              BUSY     <= 1'b1;
              MAC_WE   <= 1'b1;
              MAC_SEL  <= 2'b01;
              OPND_SEL <= 1'b0;
            end else if (is_mulw(OP) || is_nox(OP)) begin
              state    <= OPB;
              BUSY     <= 1'b1;
              MAC_WE   <= 1'b1;
              MAC_SEL  <= last_sel(OP, TGT);
              OPND_SEL <= 1'b0;
            end
          end
        end
        OPA: begin
          state    <= OPB;
          MAC_WE   <= 1'b1;
          MAC_SEL  <= last_sel(op_q, tgt_q);
          OPND_SEL <= 1'b1;
        end
        OPB: begin
          MAC_WE   <= 1'b0;
          MAC_SEL  <= '0;
          OPND_SEL <= 1'b0;
          if (is_nox(op_q)) begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end else begin
            state <= EXEC;
            cnt   <= lat_of(op_q);
          end
        end
        EXEC: begin
          cnt <= cnt - 3'd1;
          if (cnt <= 3'd1) begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Randomized bench for mac_sequencer against a phase-queue reference model.
// Each accepted op expands into a list of per-CE_R-cycle output phases.
module tb_mac_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce_r = 1'b0;
  logic       req = 1'b0;
  logic [3:0] op = '0;
  logic       sat = 1'b0;
  logic [1:0] tgt = '0;
  logic       rd_mac = 1'b0;
  logic       ack, stall, busy, opnd_sel, mac_s, mac_we;
  logic [1:0] mac_sel;
  logic [3:0] mac_op;

  mac_sequencer dut (
    .CLK(clk), .RST_N(rst_n), .CE_R(ce_r), .REQ(req), .OP(op), .SAT(sat),
    .TGT(tgt), .RD_MAC(rd_mac), .ACK(ack), .STALL(stall), .BUSY(busy),
    .OPND_SEL(opnd_sel), .MAC_SEL(mac_sel), .MAC_OP(mac_op), .MAC_S(mac_s),
    .MAC_WE(mac_we)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       we;
    logic [1:0] sel;
    logic       opnd;
  } ph_t;

  ph_t        q[$];
  logic [3:0] m_op = '0;
  logic       m_sat = 1'b0;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: how many EXEC cycles an op occupies and its write-phase list.
  function automatic int exec_cycles(input logic [3:0] o);
    case (o)
      4'b0110, 4'b0111: return 1;
      4'b0001:          return 2;
      4'b0010, 4'b0011: return 3;
      4'b1011:          return 2;
      4'b1001:          return 3;
      default:          return 0;
    endcase
  endfunction

  task automatic model_accept(input logic [3:0] o, input logic s, input logic [1:0] t);
    logic [1:0] fsel;
    bit two, one;
    m_op  = o;
    m_sat = s;
    two = (o == 4'd1 || o == 4'd2 || o == 4'd3 || o == 4'd9 || o == 4'd11);
    one = (o == 4'd0 || o == 4'd8 || o == 4'd15 || o == 4'd6 || o == 4'd7);
    fsel = (o == 4'd0 || o == 4'd8) ? t : (o == 4'd15) ? 2'b11 : 2'b10;
    if (two) begin
      q.push_back('{we: 1'b1, sel: 2'b01, opnd: 1'b0});
      q.push_back('{we: 1'b1, sel: fsel, opnd: 1'b1});
    end else if (one) begin
      q.push_back('{we: 1'b1, sel: fsel, opnd: 1'b0});
    end
    if (two || one)
      for (int i = 0; i < exec_cycles(o); i++) q.push_back('{we: 1'b0, sel: 2'b00, opnd: 1'b0});
  endtask

  // One clock: drive inputs, compare at negedge, advance the model at the posedge.
  task automatic step(input logic r, input logic [3:0] o, input logic s, input logic [1:0] t,
                      input logic rd, input logic ce, output logic got_ack);
    ph_t e;
    bit  b;
    req = r; op = o; sat = s; tgt = t; rd_mac = rd; ce_r = ce;
    @(negedge clk);
    b = (q.size() != 0);
    e = b ? q[0] : '0;
    got_ack = ack;
    check("ack",      32'(ack),      32'(r & ce & ~b & rst_n));
    check("stall",    32'(stall),    32'(b & (r | rd)));
    check("busy",     32'(busy),     32'(b));
    check("mac_we",   32'(mac_we),   32'(e.we));
    check("mac_sel",  32'(mac_sel),  32'(e.sel));
    check("opnd_sel", 32'(opnd_sel), 32'(e.opnd));
    check("mac_op",   32'(mac_op),   32'(m_op));
    check("mac_s",    32'(mac_s),    32'(m_sat));
    @(posedge clk);
    if (rst_n && ce) begin
      if (b) void'(q.pop_front());
      else if (r) model_accept(o, s, t);
    end
    #1;
  endtask

  initial begin
    logic a;
    int   n;
    // Reset state.
    step(1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b1, a);
    step(1'b0, 4'd0, 1'b0, 2'd0, 1'b1, 1'b1, a);
    rst_n = 1'b1;

    // MAC.L with saturation, then idle to drain.
    step(1'b1, 4'b1001, 1'b1, 2'd0, 1'b0, 1'b1, a);
    check("macl_ack", 32'(a), 32'd1);
    n = 0;
    while (busy_model() && n < 20) begin step(1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b1, a); n++; end
    check("macl_busy_len", 32'(n), 32'd5);

    // MULS.W then a MAC read held until it clears.
    step(1'b1, 4'b0111, 1'b0, 2'd0, 1'b0, 1'b1, a);
    repeat (3) step(1'b0, 4'd0, 1'b0, 2'd0, 1'b1, 1'b1, a);
    // LDS MACH, CLRMAC.
    step(1'b1, 4'b0000, 1'b0, 2'b10, 1'b0, 1'b1, a);
    step(1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b1, a);
    step(1'b1, 4'b1111, 1'b0, 2'b00, 1'b0, 1'b1, a);
    step(1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b1, a);

    // DMULS.L held behind MUL.L: second accept 5 cycles after the first.
    step(1'b1, 4'b0001, 1'b0, 2'd0, 1'b0, 1'b1, a);
    n = 0;
    do begin step(1'b1, 4'b0011, 1'b0, 2'd0, 1'b0, 1'b1, a); n++; end while (!a && n < 20);
    check("b2b_gap", 32'(n), 32'd5);
    repeat (6) step(1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b1, a);

    // Random traffic.
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 9) < 4), 4'($urandom_range(0, 15)), 1'($urandom),
           2'($urandom), ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 7), a);
    repeat (12) step(1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b1, a);

    // DMULU.L with CE_R toggling, then reset while in EXEC.
    step(1'b1, 4'b0010, 1'b1, 2'd0, 1'b0, 1'b1, a);
    for (int i = 0; i < 6; i++) step(1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'(i % 2), a);
    req = 1'b1; rd_mac = 1'b1; ce_r = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy",  32'(busy),   32'd0);
    check("rst_stall", 32'(stall),  32'd0);
    check("rst_we",    32'(mac_we), 32'd0);
    check("rst_op",    32'(mac_op), 32'd0);
    q.delete(); m_op = '0; m_sat = 1'b0;
    req = 1'b0; rd_mac = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) step(1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b1, a);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic bit busy_model();
    return q.size() != 0;
  endfunction

endmodule

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
- Controls the shared MACH/MACL multiply-accumulate datapath of the SH core.
- Takes decoded multiply, MAC, LDS-to-MAC and CLRMAC requests from the pipeline. Sequences them into single-phase or two-phase operand writes on the MAC_SEL/MAC_OP/MAC_S/MAC_WE interface.
- Emulates per-instruction multiplier occupancy with a countdown, and stalls the pipeline on structural and read-after-write hazards against MACH/MACL.

Parameters:
- LAT_MULW, 1: EXEC cycles for MULU.W/MULS.W.
- LAT_MULL, 2: EXEC cycles for MUL.L.
- LAT_DMUL, 3: EXEC cycles for DMULU.L/DMULS.L.
- LAT_MACW, 2: EXEC cycles for MAC.W.
- LAT_MACL, 3: EXEC cycles for MAC.L.
- Every LAT_* must be in the range 1..7.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  asynchronous active-low reset.
- CE_R  in  1  rising-phase clock enable; all state advances only when CE_R=1.
- REQ  in  1  MAC operation request from the decoder.
- OP  in  4  operation code, same encoding as the MAC_OP datapath field.
- SAT  in  1  S flag value for MAC.x.
- TGT  in  2  LDS target (bit0=MACL, bit1=MACH); only meaningful for OP 0000/1000.
- RD_MAC  in  1  pipeline wants to read MACH/MACL (STS MACx, STS.L MACx).
- ACK  out  1  request accepted this cycle.
- STALL  out  1  pipeline must hold.
- BUSY  out  1  state != IDLE.
- OPND_SEL  out  1  0 = first operand on CBUS_DI, 1 = second.
- MAC_SEL  out  2  datapath register select.
- MAC_OP  out  4  datapath opcode (latched OP).
- MAC_S  out  1  latched SAT.
- MAC_WE  out  1  datapath write strobe.

Behaviour:
- Reset: state=IDLE, counter=0, latched OP/SAT/TGT=0. All outputs 0.
- Reset mid-operation aborts immediately; no further MAC_WE.
- States: IDLE, OPA, OPB, EXEC.
- Op classes:
  - Two-phase: 0001, 0010, 0011, 1001, 1011.
  - Single-phase with exec: 0110, 0111.
  - Single-phase, no exec: 0000, 1000 (LDS), 1111 (CLRMAC).
  - NOP: all other codes.
- IDLE: when REQ=1 and CE_R=1, latch OP, SAT and TGT, then assert ACK combinationally that cycle.
  - Two-phase → OPA.
  - Single-phase → OPB.
  - NOP → stays IDLE, ACK only.
- OPA: MAC_WE=1, MAC_SEL=01, OPND_SEL=0. On CE_R → OPB.
- OPB: MAC_WE=1, OPND_SEL=1 for two-phase ops, else 0.
  - MAC_SEL: 10 for mult/MAC ops; TGT for LDS; 11 for CLRMAC.
  - On CE_R: mult/MAC ops load counter with LAT for the op and go to EXEC. LDS/CLRMAC → IDLE.
- EXEC: MAC_WE=0, MAC_SEL=00. Counter decrements on each CE_R. When it reaches 1 and CE_R=1 → IDLE, so EXEC lasts exactly LAT CE_R cycles.
- In states other than OPA/OPB, MAC_WE=0 and MAC_SEL=00.
- MAC_OP and MAC_S always drive the latched values.
- STALL = (REQ & state!=IDLE) | (RD_MAC & state!=IDLE).
- ACK = REQ & CE_R & state==IDLE. REQ and ACK are never both 1 while STALL=1.
- RD_MAC in IDLE: no stall. A read issued on the cycle of a new REQ accept is not stalled, because the read precedes the op in program order.
- CE_R=0: state, counter and outputs hold; ACK=0. STALL is still evaluated from state.
- Back-to-back: a REQ held through EXEC is accepted on the first IDLE cycle. There are no bubbles beyond the mandated states.
- Latched OP/SAT/TGT change only on ACK.

Test Plan:
- MAC.L, OP=1001, SAT=1, CE_R=1 continuous:
  - ACK at t0.
  - t1: MAC_SEL=01, WE=1, OPND_SEL=0.
  - t2: MAC_SEL=10, OPND_SEL=1, MAC_S=1.
  - EXEC t3–t5, IDLE at t6; BUSY t1–t5.
- MULS.W, OP=0111, followed immediately by RD_MAC:
  - Single write at t1 with MAC_SEL=10.
  - EXEC 1 cycle; STALL=1 t1–t2, 0 at t3.
- LDS MACH, OP=0000, TGT=10: one WE cycle with MAC_SEL=10, then IDLE; never enters EXEC.
- CLRMAC, OP=1111: one cycle with MAC_SEL=11, WE=1.
- DMULS.L held behind MUL.L (REQ asserted throughout):
  - Second ACK exactly 1 cycle after the first op's EXEC ends.
  - STALL=1 until that cycle.
- CE_R toggling 1/0 during a DMULU.L: state advances only on CE_R=1 cycles. Asserting RST_N=0 in EXEC clears BUSY/STALL/MAC_WE asynchronously, and no writes follow.
